// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared definitions for the multiplexed 7-segment scan controller.
//   BLANK       : nibble value that drives a dark digit
//   upd_state_e : update FSM state encoding (IDLE -> CONV -> COMMIT)
//   seg_encode  : nibble to active-high segment byte (bit0=a .. bit6=g, bit7=dp=0)
//   max_dec     : 10^fd - 1, the largest value a field of fd digits can display
package seg_scan_pkg;

    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } upd_state_e;

    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = 8'h00;
        endcase
        return seg;
    endfunction

    // Up to 8 digits, so 10^8 - 1 still fits in 32 bits.
    function automatic logic [31:0] max_dec(input int fd);
        logic [31:0] m;
        m = 32'd1;
        for (int i = 0; i < fd; i++) begin
            m = m * 32'd10;
        end
        return m - 32'd1;
    endfunction

endpackage

// File: rtl/seg_bcd_conv.sv
// seg_bcd_conv: sequential saturating binary-to-BCD converter (double dabble).
// A start pulse loads the (clamped) value; one bit is shifted per cycle for
// exactly VAL_W cycles. done_o is high during the cycle that performs the final
// shift, so bcd_o holds the finished result from the following cycle until the
// next start.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : load value_i and begin conversion (ignored-safe while busy)
//   value_i    : unsigned binary input
//   done_o     : last shift happens this cycle
//   bcd_o      : FD packed BCD digits, LSD in bits [3:0]
module seg_bcd_conv
    import seg_scan_pkg::*;
#(
    parameter int VAL_W = 16,
    parameter int FD    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [VAL_W-1:0] value_i,
    output logic             done_o,
    output logic [4*FD-1:0]  bcd_o
);

    localparam int SRW = VAL_W + 4 * FD;
    localparam int CW  = $clog2(VAL_W + 1);
    localparam logic [31:0]   MAX_DEC = max_dec(FD);
    localparam logic [CW-1:0] LAST    = CW'(VAL_W - 1);

    logic [SRW-1:0]   sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [VAL_W-1:0] sat_value;
    logic [SRW-1:0]   adj;

    // Clamp to all 9s so the BCD field never overflows.
    always_comb begin
        sat_value = value_i;
        if (32'(value_i) > MAX_DEC) begin
            sat_value = MAX_DEC[VAL_W-1:0];
        end
    end

    // Add-3 correction on every BCD nibble that is 5 or more, before the shift.
    always_comb begin
        adj = sr_q;
        for (int i = 0; i < FD; i++) begin
            if (sr_q[VAL_W+4*i +: 4] >= 4'd5) begin
                adj[VAL_W+4*i +: 4] = sr_q[VAL_W+4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            sr_d   = {{(4*FD){1'b0}}, sat_value};
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sr_d  = {adj[SRW-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done_o = busy_q && (cnt_q == LAST);
    assign bcd_o  = sr_q[SRW-1 -: 4*FD];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: N-digit multiplexed 7-segment scan controller.
// Owners write binary values into fields through a valid/ready port; each value
// is saturated, converted to BCD, optionally leading-zero blanked and written
// atomically into the field's digit registers. Digits are scanned onto shared
// segment / common lines with a one-cycle ghost blank after each scan step.
//
// Handshake: an update is taken on a rising clk edge where upd_valid && upd_ready.
// upd_ready is low from that edge until the field write has completed; a
// request presented while upd_ready is low is dropped, not queued.
//
// Build option: define SEG_SCAN_BLINK_EN to add the blink phase register and
// per-field blink flags. Without it tick_blink and upd_blink are ignored.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   tick_scan   : strobe, advance scan position
//   tick_blink  : strobe, toggle blink phase
//   upd_valid / upd_ready / upd_field / upd_value / upd_lzb / upd_blink : update port
//   seg_data    : active-high segments (dp always 0)
//   seg_com     : active-low digit commons
//   dbg_state   : current update FSM state
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int FIELDS = 2,
    parameter int VAL_W  = 16,
    parameter int FW     = (FIELDS > 1) ? $clog2(FIELDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_scan,
    input  logic              tick_blink,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [FW-1:0]     upd_field,
    input  logic [VAL_W-1:0]  upd_value,
    input  logic              upd_lzb,
    input  logic              upd_blink,
    output logic [7:0]        seg_data,
    output logic [DIGITS-1:0] seg_com,
    output logic [1:0]        dbg_state
);

    localparam int FD = DIGITS / FIELDS;
    localparam int SW = $clog2(DIGITS);

    upd_state_e state_q, state_d;
    logic       rdy_q;
    logic       accept;
    logic       conv_start;
    logic       conv_done;
    logic [4*FD-1:0] conv_bcd;
    logic [FW-1:0]   fld_q;
    logic            lzb_q;

    logic [3:0] digit_q [DIGITS];
    logic [3:0] digit_d [DIGITS];
    logic [3:0] nib     [FD];
    logic       blank_run;

    logic [SW-1:0]     scan_idx_q, scan_idx_d;
    logic [7:0]        seg_data_q, seg_data_d;
    logic [DIGITS-1:0] seg_com_q, seg_com_d;
    logic [3:0]        cur_nib;
    logic              cur_dark;

    // ------------------------------------------------------------------
    // Update FSM
    // ------------------------------------------------------------------
    // rdy_q is registered so upd_ready stays low throughout reset.
    assign accept = (state_q == ST_IDLE) && rdy_q && upd_valid;

    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    conv_start = 1'b1;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            fld_q   <= '0;
            lzb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == ST_IDLE);
            if (accept) begin
                fld_q <= upd_field;
                lzb_q <= upd_lzb;
            end
        end
    end

    assign upd_ready = rdy_q;
    assign dbg_state = state_q;

    seg_bcd_conv #(
        .VAL_W(VAL_W),
        .FD   (FD)
    ) u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(conv_start),
        .value_i(upd_value),
        .done_o (conv_done),
        .bcd_o  (conv_bcd)
    );

    // ------------------------------------------------------------------
    // Leading-zero blanking: walk from the MSD down, blanking zeros until
    // the first nonzero digit. The LSD always stays visible.
    // ------------------------------------------------------------------
    always_comb begin
        blank_run = lzb_q;
        for (int k = FD - 1; k >= 0; k--) begin
            nib[k] = conv_bcd[4*k +: 4];
            if ((k != 0) && blank_run && (nib[k] == 4'd0)) begin
                nib[k] = BLANK;
            end else begin
                blank_run = 1'b0;
            end
        end
    end

    // All FD digits of the target field are written in the single COMMIT cycle.
    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            digit_d[d] = digit_q[d];
            if ((state_q == ST_COMMIT) && (int'(fld_q) == d / FD)) begin
                digit_d[d] = nib[d % FD];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < DIGITS; d++) begin
                digit_q[d] <= BLANK;
            end
        end else begin
            for (int d = 0; d < DIGITS; d++) begin
                digit_q[d] <= digit_d[d];
            end
        end
    end

    // ------------------------------------------------------------------
    // Blink option
    // ------------------------------------------------------------------
`ifdef SEG_SCAN_BLINK_EN
    logic              phase_q;
    logic              blink_flag_q;
    logic [FIELDS-1:0] blink_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= 1'b0;
            blink_flag_q <= 1'b0;
            blink_q      <= '0;
        end else begin
            if (tick_blink) begin
                phase_q <= ~phase_q;
            end
            if (accept) begin
                blink_flag_q <= upd_blink;
            end
            if (state_q == ST_COMMIT) begin
                for (int f = 0; f < FIELDS; f++) begin
                    if (int'(fld_q) == f) begin
                        blink_q[f] <= blink_flag_q;
                    end
                end
            end
        end
    end

    always_comb begin
        cur_dark = 1'b0;
        for (int f = 0; f < FIELDS; f++) begin
            if ((int'(scan_idx_q) / FD == f) && blink_q[f] && phase_q) begin
                cur_dark = 1'b1;
            end
        end
    end
`else
    logic unused_blink;
    assign unused_blink = tick_blink ^ upd_blink;
    assign cur_dark     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Scan and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        scan_idx_d = scan_idx_q;
        if (tick_scan) begin
            scan_idx_d = (scan_idx_q == SW'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
        end
    end

    assign cur_nib = digit_q[scan_idx_q];

    // The edge that takes tick_scan registers an all-dark frame (ghost blank);
    // the next edge shows the digit at the new scan position.
    always_comb begin
        seg_com_d  = ~(DIGITS'(1) << scan_idx_q);
        seg_data_d = cur_dark ? 8'h00 : seg_encode(cur_nib);
        if (tick_scan) begin
            seg_com_d  = '1;
            seg_data_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx_q <= '0;
            seg_data_q <= 8'h00;
            seg_com_q  <= '1;
        end else begin
            scan_idx_q <= scan_idx_d;
            seg_data_q <= seg_data_d;
            seg_com_q  <= seg_com_d;
        end
    end

    assign seg_data = seg_data_q;
    assign seg_com  = seg_com_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl
// (DIGITS=8, FIELDS=2, VAL_W=16, so 4 digits per field).
// Field readback packs the four segment codes of a field into 32 bits with the
// MSD in the top byte, e.g. 3000 -> 32'h4F3F3F3F.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 8;
    localparam int FIELDS = 2;
    localparam int VAL_W  = 16;
    localparam int FD     = DIGITS / FIELDS;
    localparam int FW     = 1;
    localparam int LAT    = VAL_W + 2;

    logic              clk;
    logic              rst_n;
    logic              tick_scan;
    logic              tick_blink;
    logic              upd_valid;
    logic              upd_ready;
    logic [FW-1:0]     upd_field;
    logic [VAL_W-1:0]  upd_value;
    logic              upd_lzb;
    logic              upd_blink;
    logic [7:0]        seg_data;
    logic [DIGITS-1:0] seg_com;
    logic [1:0]        dbg_state;

    int total;
    int bad;
    int exp_idx;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    seg_scan_ctrl #(
        .DIGITS(DIGITS),
        .FIELDS(FIELDS),
        .VAL_W (VAL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_scan (tick_scan),
        .tick_blink(tick_blink),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_field (upd_field),
        .upd_value (upd_value),
        .upd_lzb   (upd_lzb),
        .upd_blink (upd_blink),
        .seg_data  (seg_data),
        .seg_com   (seg_com),
        .dbg_state (dbg_state)
    );

    // ---------------- driver tasks ----------------
    // One scan step: returns the ghost-blank frame and the following digit frame.
    task automatic tick_once(output logic [7:0] g_data, output logic [7:0] g_com,
                             output logic [7:0] d_data, output logic [7:0] d_com);
        @(posedge clk); #1 tick_scan = 1'b1;
        @(posedge clk); #1 tick_scan = 1'b0;
        exp_idx = (exp_idx + 1) % DIGITS;
        g_data = seg_data;
        g_com  = seg_com;
        @(posedge clk); #1;
        d_data = seg_data;
        d_com  = seg_com;
    endtask

    task automatic read_field(input int f, output logic [31:0] codes, output logic com_ok);
        logic [7:0] gd, gc, dd, dc;
        int d;
        codes  = '0;
        com_ok = 1'b1;
        dd     = '0;
        dc     = '0;
        for (int k = 0; k < FD; k++) begin
            d = f * FD + k;
            for (int n = 0; n < DIGITS; n++) begin
                tick_once(gd, gc, dd, dc);
                if (exp_idx == d) break;
            end
            codes[8*k +: 8] = dd;
            if (dc !== ~(8'd1 << d)) com_ok = 1'b0;
        end
    endtask

    // Issues one update and returns cycles from acceptance until upd_ready is 1 again.
    task automatic do_update(input int f, input int v, input logic lzb, input logic blk,
                             output int lat);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (upd_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        upd_valid = 1'b1;
        upd_field = FW'(f);
        upd_value = VAL_W'(v);
        upd_lzb   = lzb;
        upd_blink = blk;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        lat = 1;
        while (upd_ready !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (upd_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b exp=0", upd_ready);
        end
        total++;
        if (seg_com !== 8'hFF) begin
            bad++; $display("FAIL reset_com got=%h exp=ff", seg_com);
        end
        total++;
        if (seg_data !== 8'h00) begin
            bad++; $display("FAIL reset_data got=%h exp=00", seg_data);
        end
        rst_n   = 1'b1;
        exp_idx = 0;
        @(posedge clk); #1;
        total++;
        if (upd_ready !== 1'b1) begin
            bad++; $display("FAIL release_ready got=%b exp=1", upd_ready);
        end
        total++;
        if (seg_com !== 8'hFE || seg_data !== 8'h00) begin
            bad++; $display("FAIL release_out got=%h/%h exp=fe/00", seg_com, seg_data);
        end
        total++;
        if (dbg_state !== 2'd0) begin
            bad++; $display("FAIL release_state got=%0d exp=0", dbg_state);
        end
    endtask

    task automatic test_dark_scan();
        logic [7:0] gd, gc, dd, dc, ec;
        for (int i = 0; i < DIGITS; i++) begin
            tick_once(gd, gc, dd, dc);
            ec = ~(8'd1 << exp_idx);
            total++;
            if (gc !== 8'hFF || gd !== 8'h00) begin
                bad++; $display("FAIL ghost_blank idx=%0d got=%h/%h exp=ff/00", exp_idx, gc, gd);
            end
            total++;
            if (dc !== ec || dd !== 8'h00) begin
                bad++; $display("FAIL dark_digit idx=%0d got=%h/%h exp=%h/00", exp_idx, dc, dd, ec);
            end
        end
    endtask

    task automatic test_field1_3000();
        int lat;
        logic [31:0] codes;
        logic ok;
        do_update(1, 3000, 1'b1, 1'b0, lat);
        total++;
        if (lat !== LAT) begin
            bad++; $display("FAIL update_latency got=%0d exp=%0d", lat, LAT);
        end
        read_field(1, codes, ok);
        total++;
        if (codes !== 32'h4F3F3F3F || ok !== 1'b1) begin
            bad++; $display("FAIL f1_3000 got=%h com_ok=%b exp=4f3f3f3f", codes, ok);
        end
        read_field(0, codes, ok);
        total++;
        if (codes !== 32'h00000000 || ok !== 1'b1) begin
            bad++; $display("FAIL f0_still_dark got=%h com_ok=%b exp=00000000", codes, ok);
        end
    endtask

    task automatic test_field0_42();
        int lat;
        logic [31:0] codes;
        logic ok;
        do_update(0, 42, 1'b1, 1'b0, lat);
        read_field(0, codes, ok);
        total++;
        if (codes !== 32'h0000665B || ok !== 1'b1) begin
            bad++; $display("FAIL f0_42_lzb got=%h com_ok=%b exp=0000665b", codes, ok);
        end
        read_field(1, codes, ok);
        total++;
        if (codes !== 32'h4F3F3F3F) begin
            bad++; $display("FAIL f1_kept got=%h exp=4f3f3f3f", codes);
        end
        do_update(0, 42, 1'b0, 1'b0, lat);
        read_field(0, codes, ok);
        total++;
        if (codes !== 32'h3F3F665B) begin
            bad++; $display("FAIL f0_42_nolzb got=%h exp=3f3f665b", codes);
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic [31:0] codes;
        logic ok;
        int          vals [4]   = '{65535, 10000, 9998, 1000};
        logic [31:0] exps [4]   = '{32'h6F6F6F6F, 32'h6F6F6F6F, 32'h6F6F6F7F, 32'h063F3F3F};
        for (int i = 0; i < 4; i++) begin
            do_update(0, vals[i], 1'b1, 1'b0, lat);
            read_field(0, codes, ok);
            total++;
            if (codes !== exps[i]) begin
                bad++; $display("FAIL sat_%0d got=%h exp=%h", vals[i], codes, exps[i]);
            end
        end
    endtask

    task automatic test_zero();
        int lat;
        logic [31:0] codes;
        logic ok;
        do_update(0, 0, 1'b1, 1'b0, lat);
        read_field(0, codes, ok);
        total++;
        if (codes !== 32'h0000003F) begin
            bad++; $display("FAIL zero_lzb got=%h exp=0000003f", codes);
        end
        do_update(0, 0, 1'b0, 1'b0, lat);
        read_field(0, codes, ok);
        total++;
        if (codes !== 32'h3F3F3F3F) begin
            bad++; $display("FAIL zero_nolzb got=%h exp=3f3f3f3f", codes);
        end
        do_update(0, 105, 1'b1, 1'b0, lat);
        read_field(0, codes, ok);
        total++;
        if (codes !== 32'h00063F6D) begin
            bad++; $display("FAIL inner_zero got=%h exp=00063f6d", codes);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] codes;
        logic ok;
        @(posedge clk); #1;
        upd_valid = 1'b1;
        upd_field = 1'b0;
        upd_value = 16'd42;
        upd_lzb   = 1'b0;
        upd_blink = 1'b0;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Stray request during CONV, dropped after one cycle.
        upd_valid = 1'b1;
        upd_field = 1'b1;
        upd_value = 16'd7;
        total++;
        if (upd_ready !== 1'b0 || dbg_state !== 2'd1) begin
            bad++; $display("FAIL conv_busy got=%b/%0d exp=0/1", upd_ready, dbg_state);
        end
        @(posedge clk); #1;
        upd_valid = 1'b0;
        lat = 4;
        while (upd_ready !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== LAT) begin
            bad++; $display("FAIL ignored_latency got=%0d exp=%0d", lat, LAT);
        end
        repeat (LAT + 4) @(posedge clk);
        #1;
        total++;
        if (upd_ready !== 1'b1) begin
            bad++; $display("FAIL stray_not_queued got=%b exp=1", upd_ready);
        end
        read_field(1, codes, ok);
        total++;
        if (codes !== 32'h4F3F3F3F) begin
            bad++; $display("FAIL f1_untouched got=%h exp=4f3f3f3f", codes);
        end
        read_field(0, codes, ok);
        total++;
        if (codes !== 32'h3F3F665B) begin
            bad++; $display("FAIL f0_b2b got=%h exp=3f3f665b", codes);
        end
    endtask

    task automatic test_reset_mid_conv();
        logic [31:0] codes;
        logic ok;
        @(posedge clk); #1;
        upd_valid = 1'b1;
        upd_field = 1'b1;
        upd_value = 16'd1234;
        upd_lzb   = 1'b0;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (upd_ready !== 1'b0 || seg_com !== 8'hFF || seg_data !== 8'h00) begin
            bad++; $display("FAIL midreset_out got=%b/%h/%h exp=0/ff/00", upd_ready, seg_com, seg_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_idx = 0;
        @(posedge clk); #1;
        total++;
        if (upd_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_ready got=%b exp=1", upd_ready);
        end
        repeat (LAT + 4) @(posedge clk);
        #1;
        read_field(1, codes, ok);
        total++;
        if (codes !== 32'h00000000 || ok !== 1'b1) begin
            bad++; $display("FAIL midreset_f1_blank got=%h com_ok=%b exp=00000000", codes, ok);
        end
        read_field(0, codes, ok);
        total++;
        if (codes !== 32'h00000000) begin
            bad++; $display("FAIL midreset_f0_blank got=%h exp=00000000", codes);
        end
    endtask

    task automatic test_blink();
        int lat;
        logic [31:0] codes;
        logic ok;
        do_update(1, 3000, 1'b1, 1'b1, lat);
        do_update(0, 42, 1'b0, 1'b0, lat);
        read_field(1, codes, ok);
        total++;
        if (codes !== 32'h4F3F3F3F) begin
            bad++; $display("FAIL blink_phase0 got=%h exp=4f3f3f3f", codes);
        end
        @(posedge clk); #1 tick_blink = 1'b1;
        @(posedge clk); #1 tick_blink = 1'b0;
        read_field(1, codes, ok);
`ifdef SEG_SCAN_BLINK_EN
        total++;
        if (codes !== 32'h00000000 || ok !== 1'b1) begin
            bad++; $display("FAIL blink_dark got=%h com_ok=%b exp=00000000", codes, ok);
        end
`else
        total++;
        if (codes !== 32'h4F3F3F3F) begin
            bad++; $display("FAIL blink_ignored got=%h exp=4f3f3f3f", codes);
        end
`endif
        read_field(0, codes, ok);
        total++;
        if (codes !== 32'h3F3F665B) begin
            bad++; $display("FAIL blink_f0_kept got=%h exp=3f3f665b", codes);
        end
        @(posedge clk); #1 tick_blink = 1'b1;
        @(posedge clk); #1 tick_blink = 1'b0;
        read_field(1, codes, ok);
        total++;
        if (codes !== 32'h4F3F3F3F) begin
            bad++; $display("FAIL blink_restored got=%h exp=4f3f3f3f", codes);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total      = 0;
        bad        = 0;
        exp_idx    = 0;
        rst_n      = 1'b0;
        tick_scan  = 1'b0;
        tick_blink = 1'b0;
        upd_valid  = 1'b0;
        upd_field  = '0;
        upd_value  = '0;
        upd_lzb    = 1'b0;
        upd_blink  = 1'b0;

        test_reset();
        test_dark_scan();
        test_field1_3000();
        test_field0_42();
        test_saturation();
        test_zero();
        test_back_to_back();
        test_reset_mid_conv();
        test_blink();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised N-digit multiplexed 7-segment scan controller, the successor to the fixed 8-digit RPM/speed display driver. Owners write binary values into independent display fields over a valid/ready port. The block converts each value to BCD sequentially, with saturation and per-field leading-zero blanking, and scans the digits onto shared segment/common lines. It sits between the vehicle-state logic and the board's 8-digit display.

## Interface
- DIGITS, 8: total scanned digits, 2..8.
- FIELDS, 2: number of fields; DIGITS % FIELDS == 0; FD = DIGITS/FIELDS digits per field.
- VAL_W, 16: binary value width, 4..16.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick_scan  in  1  one-cycle strobe; advances the scan position.
- tick_blink  in  1  one-cycle strobe; toggles the blink phase (used only with the macro).
- upd_valid  in  1  update request.
- upd_ready  out  1  block can accept an update.
- upd_field  in  max(1,$clog2(FIELDS))  target field.
- upd_value  in  VAL_W  unsigned binary value.
- upd_lzb  in  1  enable leading-zero blanking for this field.
- upd_blink  in  1  enable blinking for this field.
- seg_data  out  8  segments, active-high, bit0=a … bit6=g, bit7=dp (always 0).
- seg_com  out  DIGITS  digit commons, active-low, one-hot-low while scanning.

## Operation
- Digit 0 is rightmost. Field f occupies digits f·FD … f·FD+FD−1; its LSD is at f·FD.
- Update FSM states: IDLE, CONV, COMMIT.
  - IDLE: upd_ready=1. On upd_valid, capture field, flags, and value, then go to CONV.
  - Saturation: if the value exceeds 10^FD−1, it is clamped to 10^FD−1 (all 9s) before conversion.
  - CONV: shift-add-3 double dabble, one bit per cycle, for exactly VAL_W cycles. The shift register is VAL_W+4·FD bits wide. upd_ready=0.
  - COMMIT: apply LZB, then write FD nibbles and the blink flag into the field registers in one cycle. Return to IDLE.
- LZB: scanning from the MSD downward, zero digits become blank (4'hF) until the first nonzero digit. The LSD is never blanked.
- Reset state of the field registers: all nibbles 4'hF (dark), blink flags 0.
- Scan:
  - scan_idx advances by 1 on tick_scan and wraps DIGITS−1 → 0.
  - In the clk after each tick_scan, all commons are driven inactive and seg_data=0 (one-cycle ghost blank). The new digit appears the following cycle.
- Encoding: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Blank (F) and any other nibble encode as 00.
- Updates to a field take effect on the display at the next registered output cycle after COMMIT. Other fields are unaffected.

## Timing
- Update latency: accept at cycle 0 (upd_valid && upd_ready), CONV on cycles 1..VAL_W, COMMIT on cycle VAL_W+1, upd_ready=1 on cycle VAL_W+2.
- upd_valid while upd_ready=0 is ignored. It is not queued; the requester must hold it.
- seg_data and seg_com are registered: one cycle after the field register/scan_idx change, plus the ghost blank cycle.
- Reset values: seg_com all 1s, seg_data 00, upd_ready 0 while rst_n=0 and 1 on the first cycle after release, scan_idx 0, blink phase 0, FSM in IDLE.
- Reset asserted mid-conversion aborts the conversion. The field registers return to blank and no partial COMMIT occurs.
- tick_scan during CONV/COMMIT scans normally. A field's digits are never shown half-written, because the COMMIT write is atomic.

## Configuration
- SEG_SCAN_BLINK_EN defined: a blink phase register toggles on tick_blink. While phase=1, digits of fields with the blink flag set output seg_data=00; commons keep scanning.
- SEG_SCAN_BLINK_EN undefined: no phase register or blink flags. tick_blink and upd_blink are ignored, and ports stay present.

## Structure
- Package seg_scan_pkg holds:
  - the 7-segment encode function and the BLANK nibble constant;
  - the FSM state typedef;
  - a constant function max_dec(FD) returning 10^FD−1.
- One sub-module, seg_bcd_conv: sequential saturating double dabble with start/done, parametrised by VAL_W and FD.

## Test plan
- Reset release, no update -> seg_com cycles one-hot-low over all 8 digits; seg_data=00 on every digit; upd_ready=1.
- Field 1 ← 3000, lzb=1 -> after VAL_W+2 cycles, digits 7..4 show 3F4F…: 4F,3F,3F,3F.
- Field 0 ← 42, lzb=1 -> digits 3..0 show 00,00,66,5B. With lzb=0 -> 3F,3F,66,5B.
- Field 0 ← 65535 (FD=4) -> saturates to 9999: 6F on all four digits. Field 0 ← 0, lzb=1 -> 00,00,00,3F.
- Second upd_valid asserted during CONV -> ignored. Reset pulsed mid-CONV -> field stays blank and upd_ready returns to 1.
- With SEG_SCAN_BLINK_EN, field 1 blink=1 and tick_blink pulsed -> digits 7..4 output 00 while field 0 keeps its value. A second tick_blink restores field 1.
